ref_blk_cline_sequencer: RTL
============================

# ref_blk_cline_sequencer

Parametrised successor to the chroma cache-line span calculator. It accepts one reference-block request (start x/y, extent), computes the number of cache lines the block spans horizontally and vertically at full width (no 2-bit modulo wrap), and clamps the span at the frame-coordinate edge. It then issues every spanned cache-line coordinate, one per handshake, in raster order. It sits between the prediction-fetch request path and the reference cache tag lookup, and serves both luma and chroma by parameter.

## Interface
- C_L_H_SIZE, 3: log2 cache-line width in pixels.
- C_L_V_SIZE, 2: log2 cache-line height in pixels.
- X_WDTH, 12: pixel x-coordinate width.
- Y_WDTH, 12: pixel y-coordinate width.
- DIM_WDTH, 4: width of rf_blk_wdt_in.
- DIM_HGT, 3: width of rf_blk_hgt_in.
- DELTA_WDTH, 2: width of the delta outputs and counters. Constraint: DIM_WDTH ≤ C_L_H_SIZE+DELTA_WDTH-1 and DIM_HGT ≤ C_L_V_SIZE+DELTA_WDTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid_in  in  1  request valid.
- req_ready_out  out  1  request accepted when high together with req_valid_in.
- start_x_in  in  X_WDTH  block start x (pixels).
- start_y_in  in  Y_WDTH  block start y (pixels).
- rf_blk_wdt_in  in  DIM_WDTH  block width minus one.
- rf_blk_hgt_in  in  DIM_HGT  block height minus one.
- delta_x_out  out  DELTA_WDTH  latched horizontal span minus one (cache lines).
- delta_y_out  out  DELTA_WDTH  latched vertical span minus one.
- cl_valid_out  out  1  cache-line coordinate valid.
- cl_ready_in  in  1  downstream accepts the coordinate.
- cl_x_out  out  X_WDTH-C_L_H_SIZE  cache-line x index.
- cl_y_out  out  Y_WDTH-C_L_V_SIZE  cache-line y index.
- cl_last_out  out  1  final coordinate of the current request.

## Operation
- Arithmetic:
  - end_x = start_x_in + rf_blk_wdt_in, computed at X_WDTH+1 bits. If bit X_WDTH is set, end_x clamps to 2^X_WDTH-1. end_y is computed the same way at Y_WDTH+1 bits.
  - base_x = start_x_in >> C_L_H_SIZE.
  - dx = (end_x >> C_L_H_SIZE) - base_x, full width, truncated to DELTA_WDTH. The parameter constraint guarantees no loss.
  - base_y and dy are computed the same way with C_L_V_SIZE.
- FSM states: IDLE, ISSUE.
  - IDLE: req_ready_out=1, cl_valid_out=0. On req_valid_in, register base_x, base_y, dx, dy into delta_x_out/delta_y_out, clear counters ix and iy to 0, and go to ISSUE. req_valid_in is ignored outside IDLE.
  - ISSUE: req_ready_out=0, cl_valid_out=1, cl_x_out=base_x+ix, cl_y_out=base_y+iy. cl_x_out and cl_y_out wrap modulo their width. cl_last_out=(ix==dx)&&(iy==dy).
  - On cl_valid_out&&cl_ready_in:
    - If cl_last_out: go to IDLE.
    - Else if ix==dx: ix←0, iy←iy+1.
    - Else: ix←ix+1.
- Backpressure: while cl_valid_out=1 and cl_ready_in=0, cl_x_out, cl_y_out and cl_last_out hold stable and cl_valid_out stays high.
- delta_x_out and delta_y_out hold their value until the next accepted request.
- Reset (including mid-request):
  - Next edge goes to IDLE and drops the in-flight request.
  - Output reset values: req_ready_out=1 (after reset deasserts), cl_valid_out=0, cl_last_out=0, cl_x_out=0, cl_y_out=0, delta_x_out=0, delta_y_out=0.
  - While reset is high, req_ready_out=0.

## Timing
- All outputs are registered. There is no combinational path from req_valid_in or cl_ready_in to any output.
- Request accepted at edge N; first cl_valid_out at cycle N+1.
- One coordinate per cycle with cl_ready_in held high.
- The last handshake at edge M returns the FSM to IDLE; req_ready_out=1 at cycle M+1.
- Per-request occupancy with no stalls: (dx+1)(dy+1)+1 cycles.

## Test plan
- start_x=5, start_y=1, wdt=2, hgt=2 -> delta_x=0, delta_y=0; one beat (0,0), last=1; req_ready_out high the cycle after.
- start_x=6, wdt=4, start_y=3, hgt=2 -> dx=1, dy=1; beats (0,0),(1,0),(0,1),(1,1); last only on the 4th beat.
- Max span: start_x=7, wdt=15, start_y=3, hgt=7 -> dx=2, dy=2; 9 beats in raster order, x 0..2 within y 0..2, last on the 9th.
- Backpressure: case 2 with cl_ready_in low for 3 cycles at beat 2 -> (1,0) held stable, no beat skipped or duplicated; req_valid_in pulsed during ISSUE is ignored.
- Clamp: start_x=4095, wdt=15, start_y=4094, hgt=7 -> dx=0, dy=0, single beat (511,1023).
- Reset mid-operation: case 3, reset high after 2 beats -> next cycle cl_valid_out=0, deltas=0; once reset deasserts, req_ready_out=1 and a new request (case 1) completes correctly.

Source files
------------

// File: rtl/ref_blk_cline_sequencer.sv
// Reference-block cache-line sequencer.
// Takes one block request (start x/y plus extent) and computes how many
// cache lines the block spans. The end coordinate is clamped at the frame
// edge. Every covered cache-line coordinate is then issued in raster order,
// one per handshake.
module ref_blk_cline_sequencer #(
    parameter int unsigned C_L_H_SIZE = 3,
    parameter int unsigned C_L_V_SIZE = 2,
    parameter int unsigned X_WDTH     = 12,
    parameter int unsigned Y_WDTH     = 12,
    parameter int unsigned DIM_WDTH   = 4,
    parameter int unsigned DIM_HGT    = 3,
    parameter int unsigned DELTA_WDTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid_in,
    output logic                         req_ready_out,
    input  logic [X_WDTH-1:0]            start_x_in,
    input  logic [Y_WDTH-1:0]            start_y_in,
    input  logic [DIM_WDTH-1:0]          rf_blk_wdt_in,
    input  logic [DIM_HGT-1:0]           rf_blk_hgt_in,
    output logic [DELTA_WDTH-1:0]        delta_x_out,
    output logic [DELTA_WDTH-1:0]        delta_y_out,
    output logic                         cl_valid_out,
    input  logic                         cl_ready_in,
    output logic [X_WDTH-C_L_H_SIZE-1:0] cl_x_out,
    output logic [Y_WDTH-C_L_V_SIZE-1:0] cl_y_out,
    output logic                         cl_last_out
);

    localparam int unsigned CLX_WDTH = X_WDTH - C_L_H_SIZE;
    localparam int unsigned CLY_WDTH = Y_WDTH - C_L_V_SIZE;

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } state_t;

    state_t                state_q;
    logic                  req_ready_q;
    logic                  cl_valid_q;
    logic                  cl_last_q;
    logic [CLX_WDTH-1:0]   cl_x_q;
    logic [CLY_WDTH-1:0]   cl_y_q;
    logic [DELTA_WDTH-1:0] delta_x_q;
    logic [DELTA_WDTH-1:0] delta_y_q;
    logic [DELTA_WDTH-1:0] ix_q;
    logic [DELTA_WDTH-1:0] iy_q;
    logic [CLX_WDTH-1:0]   base_x_q;
    logic [CLY_WDTH-1:0]   base_y_q;

    logic [X_WDTH:0]       sum_x;
    logic [Y_WDTH:0]       sum_y;
    logic [X_WDTH-1:0]     end_x;
    logic [Y_WDTH-1:0]     end_y;
    logic [CLX_WDTH-1:0]   base_x;
    logic [CLY_WDTH-1:0]   base_y;
    logic [CLX_WDTH-1:0]   span_x;
    logic [CLY_WDTH-1:0]   span_y;
    logic [DELTA_WDTH-1:0] dx;
    logic [DELTA_WDTH-1:0] dy;
    logic [DELTA_WDTH-1:0] ix_nxt;
    logic [DELTA_WDTH-1:0] iy_nxt;
    logic                  row_end;
    logic                  unused_bits;

    // Request-side span arithmetic: clamp the end at the frame edge, then
    // the span is the difference of the cache-line indices.
    always_comb begin
        sum_x  = (X_WDTH + 1)'(start_x_in) + (X_WDTH + 1)'(rf_blk_wdt_in);
        sum_y  = (Y_WDTH + 1)'(start_y_in) + (Y_WDTH + 1)'(rf_blk_hgt_in);
        end_x  = sum_x[X_WDTH] ? {X_WDTH{1'b1}} : sum_x[X_WDTH-1:0];
        end_y  = sum_y[Y_WDTH] ? {Y_WDTH{1'b1}} : sum_y[Y_WDTH-1:0];
        base_x = start_x_in[X_WDTH-1:C_L_H_SIZE];
        base_y = start_y_in[Y_WDTH-1:C_L_V_SIZE];
        span_x = end_x[X_WDTH-1:C_L_H_SIZE] - base_x;
        span_y = end_y[Y_WDTH-1:C_L_V_SIZE] - base_y;
        // The parameter constraint keeps the span within DELTA_WDTH bits.
        dx     = span_x[DELTA_WDTH-1:0];
        dy     = span_y[DELTA_WDTH-1:0];
    end

    // Issue-side counter stepping for the next coordinate.
    always_comb begin
        ix_nxt  = ix_q + 1'b1;
        iy_nxt  = iy_q + 1'b1;
        row_end = (ix_q == delta_x_q);
    end

    assign unused_bits = ^{end_x[C_L_H_SIZE-1:0], end_y[C_L_V_SIZE-1:0],
                           span_x[CLX_WDTH-1:DELTA_WDTH], span_y[CLY_WDTH-1:DELTA_WDTH]};

    // Request/issue FSM; every output is a register so that nothing is
    // combinationally dependent on req_valid_in or cl_ready_in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b0;
            cl_valid_q  <= 1'b0;
            cl_last_q   <= 1'b0;
            cl_x_q      <= '0;
            cl_y_q      <= '0;
            delta_x_q   <= '0;
            delta_y_q   <= '0;
            ix_q        <= '0;
            iy_q        <= '0;
            base_x_q    <= '0;
            base_y_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    cl_valid_q  <= 1'b0;
                    // Acceptance is gated by the registered ready so that the
                    // first cycle after reset never takes a request.
                    if (req_ready_q && req_valid_in) begin
                        base_x_q    <= base_x;
                        base_y_q    <= base_y;
                        delta_x_q   <= dx;
                        delta_y_q   <= dy;
                        ix_q        <= '0;
                        iy_q        <= '0;
                        cl_x_q      <= base_x;
                        cl_y_q      <= base_y;
                        cl_last_q   <= (dx == '0) && (dy == '0);
                        req_ready_q <= 1'b0;
                        cl_valid_q  <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (cl_ready_in) begin
                        if (cl_last_q) begin
                            cl_valid_q  <= 1'b0;
                            cl_last_q   <= 1'b0;
                            req_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end else if (row_end) begin
                            ix_q      <= '0;
                            iy_q      <= iy_nxt;
                            cl_x_q    <= base_x_q;
                            cl_y_q    <= base_y_q + CLY_WDTH'(iy_nxt);
                            cl_last_q <= (delta_x_q == '0) && (iy_nxt == delta_y_q);
                        end else begin
                            ix_q      <= ix_nxt;
                            cl_x_q    <= base_x_q + CLX_WDTH'(ix_nxt);
                            cl_last_q <= (ix_nxt == delta_x_q) && (iy_q == delta_y_q);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_out = req_ready_q;
    assign cl_valid_out  = cl_valid_q;
    assign cl_last_out   = cl_last_q;
    assign cl_x_out      = cl_x_q;
    assign cl_y_out      = cl_y_q;
    assign delta_x_out   = delta_x_q;
    assign delta_y_out   = delta_y_q;

endmodule
